// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round functions.
// Used by the round engine and the W scheduler.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 compression round; state packed a=[255:224] .. h=[31:0].
module sha256_round_step
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  word_t        k_i,
  input  word_t        w_i,
  output logic [255:0] state_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one round per accepted W word, 64 words per block.
// SHA256_FEEDFORWARD_EN adds the chaining value into the result (Davies-Meyer).
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [8*WORD_W-1:0] hash_in,
  input  logic                w_valid,
  input  logic [WORD_W-1:0]   w_word,
  output logic                w_ready,
  output logic [5:0]          w_index,
  output logic                busy,
  output logic                done,
  output logic [8*WORD_W-1:0] hash_out
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [255:0] work_q, work_d;
  logic [5:0]   t_q, t_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic [255:0] work_next;
  logic [255:0] result;

  sha256_round_step u_step (
    .state_i (work_q),
    .k_i     (K[t_q]),
    .w_i     (w_word),
    .state_o (work_next)
  );

`ifdef SHA256_FEEDFORWARD_EN
  logic [255:0] hash_save_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hash_save_q <= '0;
    end else if (state_q == IDLE && start) begin
      hash_save_q <= hash_in;
    end
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < 8; i++) begin
      result[32*i +: 32] = hash_save_q[32*i +: 32] + work_next[32*i +: 32];
    end
  end
`else
  assign result = work_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      t_q        <= '0;
      hash_out_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      t_q        <= t_d;
      hash_out_q <= hash_out_d;
    end
  end

  // hash_out is captured on the last transfer so it is valid alongside done in FINAL
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    t_d        = t_q;
    hash_out_d = hash_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          work_d  = hash_in;
        end
      end
      LOAD: begin
        state_d = ROUND;
        t_d     = '0;
      end
      ROUND: begin
        if (w_valid) begin
          work_d = work_next;
          t_d    = t_q + 6'd1;
          if (t_q == LAST_T) begin
            state_d    = FINAL;
            hash_out_d = result;
          end
        end
      end
      FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign w_ready  = (state_q == ROUND);
  assign w_index  = t_q;
  assign busy     = (state_q == LOAD) || (state_q == ROUND);
  assign done     = (state_q == FINAL);
  assign hash_out = hash_out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine against a plain SHA-256 compression model.
// Expectations follow SHA256_FEEDFORWARD_EN when the bench is built with it.
module tb_sha256_round_engine;

`ifdef SHA256_FEEDFORWARD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  localparam logic [255:0] IV_C = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clock;
  logic         reset;
  logic         start;
  logic [255:0] hash_in;
  logic         w_valid;
  logic [31:0]  w_word;
  logic         w_ready;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int tests_run;
  int tests_failed;

  sha256_round_engine dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .hash_in  (hash_in),
    .w_valid  (w_valid),
    .w_word   (w_word),
    .w_ready  (w_ready),
    .w_index  (w_index),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress_raw(input logic [255:0] h_in, input logic [31:0] w [64]);
    logic [31:0] v [8];
    logic [31:0] s0, s1, chv, mjv, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = h_in[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1  = v[7] + s1 + chv + KT[t] + w[t];
      s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2  = s0 + mjv;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] addw(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] subw(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] expect_out(input logic [255:0] h_in, input logic [31:0] w [64]);
    logic [255:0] raw;
    raw = compress_raw(h_in, w);
    return FF ? addw(h_in, raw) : raw;
  endfunction

  task automatic build_abc_w(output logic [31:0] w [64]);
    logic [31:0] g0, g1;
    for (int t = 0; t < 16; t++) w[t] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      g0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      g1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + g0 + w[t-7] + g1;
    end
  endtask

  // Drives one block; lat counts cycles from the start cycle to the first done (-1 on timeout).
  task automatic run_block(input logic [255:0] hin, input logic [31:0] w [64], input int stall [64],
                           input bit inject, input int tail,
                           output logic [255:0] hout, output logic [255:0] hhold,
                           output int lat, output int ndone, output bit idx_ok);
    int t, st, cyc;
    hout = '0; hhold = '0; lat = -1; ndone = 0; idx_ok = 1'b1;
    t = 0; st = 0; cyc = 0;
    @(negedge clock);
    start = 1'b1; hash_in = hin; w_valid = 1'b1; w_word = $urandom;
    while (cyc < 3000) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      hash_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          hout = hash_out;
        end
      end
      if (lat >= 0 && cyc == lat + tail) begin
        hhold = hash_out;
        break;
      end
      if (w_ready && t < 64) begin
        if (w_index !== 6'(t)) idx_ok = 1'b0;
        if (st < stall[t]) begin
          st++;
          w_valid = 1'b0;
          w_word = $urandom;
        end else begin
          st = 0;
          w_valid = 1'b1;
          w_word = w[t];
          if (inject && t == 10) begin
            start = 1'b1;
            hash_in = ~hin;
          end
          t++;
        end
      end else begin
        w_valid = 1'($urandom_range(0, 1));
        w_word = $urandom;
      end
    end
    w_valid = 1'b0;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; w_valid = 1'b0; w_word = '0; hash_in = '1;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({w_ready, w_index, busy, done} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready=%b index=%0d busy=%b done=%b, want all 0", w_ready, w_index, busy, done);
    end
    tests_run++;
    if (hash_out !== 256'h0) begin
      tests_failed++;
      $display("FAIL reset_hash: got %h want 0", hash_out);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_abc();
    logic [31:0] w [64];
    int stall [64];
    logic [255:0] ho, hh, exp_h;
    int lat, nd;
    bit iok;
    build_abc_w(w);
    foreach (stall[i]) stall[i] = 0;
    exp_h = FF ? ABC_DIGEST : subw(ABC_DIGEST, IV_C);
    run_block(IV_C, w, stall, 1'b0, 3, ho, hh, lat, nd, iok);
    tests_run++;
    if (lat != 66) begin
      tests_failed++;
      $display("FAIL abc_latency: got %0d want 66", lat);
    end
    tests_run++;
    if (ho !== exp_h) begin
      tests_failed++;
      $display("FAIL abc_hash: got %h want %h", ho, exp_h);
    end
    tests_run++;
    if (hh !== exp_h) begin
      tests_failed++;
      $display("FAIL abc_hold: got %h want %h", hh, exp_h);
    end
    tests_run++;
    if (nd != 1 || !iok) begin
      tests_failed++;
      $display("FAIL abc_done_index: got done_count=%0d index_ok=%0d want 1 and 1", nd, iok);
    end
  endtask

  task automatic test_stalls();
    logic [31:0] w [64];
    int stall [64];
    logic [255:0] ho, hh, exp_h;
    int lat, nd;
    bit iok;
    build_abc_w(w);
    foreach (stall[i]) stall[i] = 0;
    stall[0] = 3; stall[17] = 5; stall[63] = 1;
    exp_h = FF ? ABC_DIGEST : subw(ABC_DIGEST, IV_C);
    run_block(IV_C, w, stall, 1'b0, 3, ho, hh, lat, nd, iok);
    tests_run++;
    if (lat != 66 + 9) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d want %0d", lat, 66 + 9);
    end
    tests_run++;
    if (ho !== exp_h) begin
      tests_failed++;
      $display("FAIL stall_hash: got %h want %h", ho, exp_h);
    end
    tests_run++;
    if (!iok) begin
      tests_failed++;
      $display("FAIL stall_index: got index_ok=%0d want 1", iok);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] w [64];
    int stall [64];
    logic [255:0] ho, hh, hin, exp_h;
    int lat, nd;
    bit iok;
    for (int i = 0; i < 64; i++) w[i] = $urandom;
    foreach (stall[i]) stall[i] = 0;
    hin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    exp_h = expect_out(hin, w);
    run_block(hin, w, stall, 1'b1, 12, ho, hh, lat, nd, iok);
    tests_run++;
    if (ho !== exp_h || lat != 66) begin
      tests_failed++;
      $display("FAIL busy_start_hash: got %h lat=%0d want %h lat=66", ho, lat, exp_h);
    end
    tests_run++;
    if (nd != 1) begin
      tests_failed++;
      $display("FAIL busy_start_done_count: got %0d want 1", nd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [64];
    int stall [64];
    logic [255:0] ho, hh, exp_h;
    int t, cyc, nd, lat;
    bit iok;
    build_abc_w(w);
    foreach (stall[i]) stall[i] = 0;
    @(negedge clock);
    start = 1'b1; hash_in = IV_C; w_valid = 1'b0;
    t = 0; cyc = 0;
    while (t < 30 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (w_ready) begin
        w_valid = 1'b1; w_word = w[t]; t++;
      end else begin
        w_valid = 1'b0;
      end
    end
    @(negedge clock);
    tests_run++;
    if (w_index !== 6'd30 || !w_ready) begin
      tests_failed++;
      $display("FAIL rstmid_reach_t30: got index=%0d ready=%b want 30 and 1", w_index, w_ready);
    end
    w_valid = 1'b1; w_word = w[30]; reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({w_ready, w_index, busy, done} !== 9'b0 || hash_out !== 256'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got ready=%b index=%0d busy=%b done=%b hash=%h want all 0",
               w_ready, w_index, busy, done, hash_out);
    end
    reset = 1'b0; w_valid = 1'b0;
    nd = 0;
    repeat (80) begin
      @(negedge clock);
      if (done) nd++;
    end
    tests_run++;
    if (nd != 0 || hash_out !== 256'h0) begin
      tests_failed++;
      $display("FAIL rstmid_no_done: got done_count=%0d hash=%h want 0 and 0", nd, hash_out);
    end
    exp_h = FF ? ABC_DIGEST : subw(ABC_DIGEST, IV_C);
    run_block(IV_C, w, stall, 1'b0, 2, ho, hh, lat, nd, iok);
    tests_run++;
    if (ho !== exp_h || lat != 66) begin
      tests_failed++;
      $display("FAIL rstmid_recover: got %h lat=%0d want %h lat=66", ho, lat, exp_h);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [64];
    logic [31:0] w2 [64];
    int stall [64];
    logic [255:0] ho, hh, d1, exp_h;
    int lat, nd;
    bit iok;
    build_abc_w(w);
    for (int i = 0; i < 64; i++) w2[i] = $urandom;
    foreach (stall[i]) stall[i] = 0;
    run_block(IV_C, w, stall, 1'b0, 0, ho, hh, lat, nd, iok);
    // start during the done cycle must be ignored; the real start follows one cycle later
    start = 1'b1;
    hash_in = ~IV_C;
    d1 = ABC_DIGEST;
    exp_h = expect_out(d1, w2);
    run_block(d1, w2, stall, 1'b0, 2, ho, hh, lat, nd, iok);
    tests_run++;
    if (lat != 66) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d want 66", lat);
    end
    tests_run++;
    if (ho !== exp_h) begin
      tests_failed++;
      $display("FAIL b2b_chain_hash: got %h want %h", ho, exp_h);
    end
  endtask

  task automatic test_random();
    logic [31:0] w [64];
    int stall [64];
    logic [255:0] ho, hh, hin, exp_h;
    int lat, nd, total;
    bit iok;
    for (int b = 0; b < 4; b++) begin
      total = 0;
      for (int i = 0; i < 64; i++) begin
        w[i] = $urandom;
        stall[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
        total += stall[i];
      end
      hin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_h = expect_out(hin, w);
      run_block(hin, w, stall, 1'b0, 2, ho, hh, lat, nd, iok);
      tests_run++;
      if (ho !== exp_h) begin
        tests_failed++;
        $display("FAIL rand%0d_hash: got %h want %h", b, ho, exp_h);
      end
      tests_run++;
      if (lat != 66 + total || !iok) begin
        tests_failed++;
        $display("FAIL rand%0d_timing: got lat=%0d index_ok=%0d want lat=%0d index_ok=1", b, lat, iok, 66 + total);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_abc();
    test_stalls();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
